// File: rtl/adder16_pkg.sv
// rtl/adder16_pkg.sv - shared types and defaults for the adder16 slice scheduler
package adder16_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int SLICE_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [SLICE_W_DEF-1:0] s;
    logic                   co;
  } slice_res_t;

endpackage

// File: rtl/adder16_slice_sched_if.sv
// rtl/adder16_slice_sched_if.sv - request/response bundle of the slice scheduler
import adder16_pkg::*;

interface adder16_slice_sched_if #(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SLICE_W = SLICE_W_DEF
);
  localparam int NSLICE = WIDTH / SLICE_W;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic [NSLICE-1:0] approx_mask;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              busy;

  modport master (
    output in_valid, a, b, cin, approx_mask, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, approx_mask, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/adder16_slice_unit.sv
// rtl/adder16_slice_unit.sv - one shared adder slice, exact or OR-based approximate
// Swap point for BMF-approximated partitions; purely combinational.
module adder16_slice_unit #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] as,
  input  logic [SLICE_W-1:0] bs,
  input  logic               ci,
  input  logic               approx,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  // Widened by one bit so the carry is taken before any truncation.
  logic [SLICE_W:0] exact;
  assign exact = {1'b0, as} + {1'b0, bs} + {{SLICE_W{1'b0}}, ci};

  always_comb begin
    s  = exact[SLICE_W-1:0];
    co = exact[SLICE_W];
    if (approx) begin
      s  = as | bs;
      co = as[SLICE_W-1] & bs[SLICE_W-1];
    end
  end

endmodule

// File: rtl/adder16_slice_sched.sv
// rtl/adder16_slice_sched.sv - WIDTH-bit add sequenced LSB-first over one shared slice
// Outputs decode from the state register or come straight from flops.
module adder16_slice_sched
  import adder16_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder16_slice_sched_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] RUN  = 2'(ST_RUN);
  localparam logic [1:0] DONE = 2'(ST_DONE);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [NSLICE-1:0] mask_q;
  logic              carry;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;

  logic [SLICE_W-1:0] as_k;
  logic [SLICE_W-1:0] bs_k;
  logic [SLICE_W-1:0] s_k;
  logic               co_k;
  logic               approx_k;

  assign as_k     = a_q[idx*SLICE_W +: SLICE_W];
  assign bs_k     = b_q[idx*SLICE_W +: SLICE_W];
  assign approx_k = mask_q[idx];

  adder16_slice_unit #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .as     (as_k),
    .bs     (bs_k),
    .ci     (carry),
    .approx (approx_k),
    .s      (s_k),
    .co     (co_k)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mask_q <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            mask_q <= bus.approx_mask;
            carry  <= bus.cin;
            sum_q  <= '0;
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*SLICE_W +: SLICE_W] <= s_k;
          carry <= co_k;
          if (idx == LAST_IDX) begin
            idx    <= '0;
            cout_q <= co_k;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder16_slice_sched.sv
// tb/tb_adder16_slice_sched.sv - directed vector table plus reset/backpressure/stream sequences
module tb_adder16_slice_sched;
  import adder16_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder16_slice_sched_if bus ();

  adder16_slice_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [3:0]  mask;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] ra, input logic [15:0] rb,
                                          input logic rc, input logic [3:0] rm);
    logic [15:0] s;
    logic        c;
    slice_res_t  r;
    logic [3:0]  x, y;
    c = rc;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      x = ra[k*4 +: 4];
      y = rb[k*4 +: 4];
      if (rm[k]) begin
        r.s  = x | y;
        r.co = x[3] & y[3];
      end else begin
        {r.co, r.s} = 5'(x) + 5'(y) + 5'(c);
      end
      s[k*4 +: 4] = r.s;
      c = r.co;
    end
    return {c, s};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("wait_in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_b, input logic tci,
                         input logic [3:0] tm, input logic hold,
                         output logic [15:0] rs, output logic rc, output int lat);
    wait_ready();
    bus.a = ta;
    bus.b = tb_b;
    bus.cin = tci;
    bus.approx_mask = tm;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 20);
    if (!bus.out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    rs = bus.sum;
    rc = bus.cout;
    if (!hold) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  logic [15:0] rs;
  logic        rc;
  int          lat;
  logic [16:0] exp_q[$];
  logic [16:0] e;
  int          issued, recv, last_acc, iter;

  initial begin
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 4'b0000, 16'h0000, 1'b1};
    vecs[1]  = '{16'h00FF, 16'h0081, 1'b0, 4'b0001, 16'h017F, 1'b0};
    vecs[2]  = '{16'h00FF, 16'h0081, 1'b0, 4'b0000, 16'h0180, 1'b0};
    vecs[3]  = '{16'h000F, 16'h0001, 1'b0, 4'b0001, 16'h000F, 1'b0};
    vecs[4]  = '{16'h1234, 16'h1111, 1'b0, 4'b0000, 16'h2345, 1'b0};
    vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 4'b0000, 16'h0001, 1'b0};
    vecs[6]  = '{16'h8421, 16'h8421, 1'b1, 4'b1111, 16'h8421, 1'b1};
    vecs[7]  = '{16'h000F, 16'h0000, 1'b1, 4'b0001, 16'h000F, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 4'b0000, 16'hFFFF, 1'b1};
    vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 4'b1000, 16'h8000, 1'b1};
    vecs[10] = '{16'h0F00, 16'h0100, 1'b0, 4'b0100, 16'h0F00, 1'b0};
    vecs[11] = '{16'hFFFF, 16'h0001, 1'b0, 4'b0010, 16'hFFF0, 1'b0};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.approx_mask = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'h0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);
    check("rel_busy", 32'(bus.busy), 32'd0);
    check("rel_sum", 32'(bus.sum), 32'h0);
    check("rel_cout", 32'(bus.cout), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].mask, 1'b0, rs, rc, lat);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].cout));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
    end

    // Backpressure: hold DONE while offering a new request each cycle.
    run_txn(16'h1234, 16'h1111, 1'b0, 4'b0000, 1'b1, rs, rc, lat);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.approx_mask = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp%0d_sum", i), 32'(bus.sum), 32'h2345);
      check($sformatf("bp%0d_cout", i), 32'(bus.cout), 32'd0);
      check($sformatf("bp%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    check("bp_hs_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_after_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_after_busy", 32'(bus.busy), 32'd0);
    check("bp_after_out_valid", 32'(bus.out_valid), 32'd0);

    // Leave cout=1 so the mid-run reset has something to clear.
    run_txn(16'hFFFF, 16'h0001, 1'b0, 4'b0000, 1'b0, rs, rc, lat);
    wait_ready();
    bus.a = 16'h1234;
    bus.b = 16'h1111;
    bus.cin = 1'b0;
    bus.approx_mask = 4'b0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("mid_sum_partial", 32'(bus.sum), 32'h0045);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'h0);
    check("mid_rst_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(16'h1234, 16'h1111, 1'b0, 4'b0000, 1'b0, rs, rc, lat);
    check("post_rst_sum", 32'(rs), 32'h2345);
    check("post_rst_cout", 32'(rc), 32'd0);

    // Streaming with out_ready tied high; operands are scrambled while busy.
    issued = 0;
    recv = 0;
    last_acc = 0;
    iter = 0;
    bus.out_ready = 1'b1;
    while (recv < 100 && iter < 1000) begin
      @(negedge clk);
      iter++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("stream%0d_sum", recv), 32'(bus.sum), 32'(e[15:0]));
          check($sformatf("stream%0d_cout", recv), 32'(bus.cout), 32'(e[16]));
        end
        recv++;
      end
      if (bus.in_ready) begin
        if (issued < 100) begin
          bus.a = 16'($urandom);
          bus.b = 16'($urandom);
          bus.cin = 1'($urandom);
          bus.approx_mask = 4'($urandom);
          bus.in_valid = 1'b1;
          exp_q.push_back(ref_add(bus.a, bus.b, bus.cin, bus.approx_mask));
          if (issued > 0) check($sformatf("stream%0d_spacing", issued), 32'(cyc - last_acc), 32'd6);
          last_acc = cyc;
          issued++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end else begin
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.cin = 1'($urandom);
        bus.approx_mask = 4'($urandom);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("stream_results_received", 32'(recv), 32'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
